// File: rtl/mux_arbiter_if.sv
// Bus between the two requesters and the mux arbiter.
//   req   : request, bit 0 = x-side, bit 1 = y-side (held high until done)
//   x, y  : requester data, mux inputs 0 and 1
//   grant : one-hot grant, 00 when nobody owns the mux
//   sel   : mux select, 0 = x, 1 = y
//   out   : registered mux output
//   valid : out holds owner data sampled on the previous edge
// master = requester side, slave = arbiter side.
interface mux_arbiter_if #(
  parameter int WIDTH = 1
);
  logic [1:0]       req;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [1:0]       grant;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic             valid;

  modport master (
    output req, x, y,
    input  grant, sel, out, valid
  );

  modport slave (
    input  req, x, y,
    output grant, sel, out, valid
  );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between an x-side and a y-side
// requester. Grants are one-hot, every change of owner passes through a
// one-cycle all-zero grant gap, and a contended owner is preempted after
// MAX_HOLD consecutive grant cycles. The mux output is registered with a
// valid flag that lags the grant by one cycle.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : mux_arbiter_if slave (req, x, y in; grant, sel, out, valid out)
module mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic         clock,
  input  logic         reset,
  mux_arbiter_if.slave bus
);

  localparam int                CNT_W     = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    SWITCH = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_q,  last_d;   // index of the most recent owner
  logic [CNT_W-1:0] hold_q,  hold_d;   // grant cycles spent by current owner
  logic [1:0]       grant_q, grant_d;
  logic             sel_q,   sel_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             valid_q, valid_d;

  logic owner;      // index of the owner while in GRANT0/GRANT1
  logic req_mine;
  logic req_other;

  function automatic state_e grant_state(input logic idx);
    return idx ? GRANT1 : GRANT0;
  endfunction

  // Next-state and register-load logic.
  // NOTE: every variable gets a default before the case statement, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    sel_d     = sel_q;
    grant_d   = 2'b00;
    out_d     = out_q;
    valid_d   = 1'b0;
    owner     = (state_q == GRANT1);
    req_mine  = bus.req[owner];
    req_other = bus.req[~owner];

    unique case (state_q)
      IDLE: begin
        unique case (bus.req)
          2'b01:   state_d = GRANT0;
          2'b10:   state_d = GRANT1;
          2'b11:   state_d = grant_state(~last_q);
          default: state_d = IDLE;
        endcase
      end
      GRANT0, GRANT1: begin
        if (!req_mine) begin
          state_d = req_other ? SWITCH : IDLE;
        end else if (req_other && (hold_q == HOLD_LAST)) begin
          state_d = SWITCH;  // contended and out of hold budget
        end
      end
      SWITCH: begin
        // last_q still names the owner that just left.
        if (bus.req[~last_q]) begin
          state_d = grant_state(~last_q);
        end else if (bus.req[last_q]) begin
          state_d = grant_state(last_q);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs follow the state being entered, so sel settles
    // on the same edge that raises or drops grant and never moves while a
    // grant bit is high.
    unique case (state_d)
      GRANT0: begin
        grant_d = 2'b01;
        sel_d   = 1'b0;
        last_d  = 1'b0;
      end
      GRANT1: begin
        grant_d = 2'b10;
        sel_d   = 1'b1;
        last_d  = 1'b1;
      end
      SWITCH: sel_d = ~last_q;
      default: ;
    endcase

    // Counter restarts on entry to a grant state and saturates at the
    // budget, so a long uncontended hold cannot wrap and postpone the
    // preemption once the other side starts asking.
    if ((state_d == GRANT0 || state_d == GRANT1) && (state_d != state_q)) begin
      hold_d = '0;
    end else if ((state_q == GRANT0 || state_q == GRANT1) && (hold_q != HOLD_LAST)) begin
      hold_d = hold_q + CNT_W'(1);
    end

    // Datapath captures the owner's data only while a grant is active.
    if (state_q == GRANT0 || state_q == GRANT1) begin
      out_d   = sel_q ? bus.y : bus.x;
      valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      grant_q <= 2'b00;
      sel_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.out   = out_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter. Three instances share one stimulus:
// MAX_HOLD = 3 (main), 2 and 1.
module tb_mux_arbiter;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mux_arbiter_if #(.WIDTH(4)) bus3 ();
  mux_arbiter_if #(.WIDTH(4)) bus2 ();
  mux_arbiter_if #(.WIDTH(4)) bus1 ();

  mux_arbiter #(.WIDTH(4), .MAX_HOLD(3)) u_dut3 (.clock(clock), .reset(reset), .bus(bus3));
  mux_arbiter #(.WIDTH(4), .MAX_HOLD(2)) u_dut2 (.clock(clock), .reset(reset), .bus(bus2));
  mux_arbiter #(.WIDTH(4), .MAX_HOLD(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));

  int checks = 0;
  int errors = 0;

  task automatic drive(input logic [1:0] r, input logic [3:0] xv, input logic [3:0] yv);
    bus3.req = r; bus3.x = xv; bus3.y = yv;
    bus2.req = r; bus2.x = xv; bus2.y = yv;
    bus1.req = r; bus1.x = xv; bus1.y = yv;
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [1:0] g, input logic s,
                            input logic v, input logic [3:0] o);
    check({tag, "_grant"}, 32'(bus3.grant), 32'(g));
    check({tag, "_sel"},   32'(bus3.sel),   32'(s));
    check({tag, "_valid"}, 32'(bus3.valid), 32'(v));
    check({tag, "_out"},   32'(bus3.out),   32'(o));
  endtask

  // Contended run from IDLE after reset, x=0, y=1.
  logic [1:0] exp_g3 [9] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
  logic       exp_s3 [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       exp_v3 [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] exp_o3 [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1};
  logic [1:0] exp_g2 [9] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
  logic [1:0] exp_g1 [9] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

  initial begin
    // Reset state
    reset = 1'b1;
    drive(2'b00, 4'h0, 4'h0);
    tick();
    tick();
    reset = 1'b0;
    check_main("reset", 2'b00, 1'b0, 1'b0, 4'h0);
    check("reset_grant2", 32'(bus2.grant), 32'h0);
    check("reset_grant1", 32'(bus1.grant), 32'h0);

    // Single x-side request for 4 cycles
    drive(2'b01, 4'h1, 4'h0);
    tick(); check_main("x_grant", 2'b01, 1'b0, 1'b0, 4'h0);
    tick(); check_main("x_beat1", 2'b01, 1'b0, 1'b1, 4'h1);
    tick(); check_main("x_beat2", 2'b01, 1'b0, 1'b1, 4'h1);
    tick(); check_main("x_beat3", 2'b01, 1'b0, 1'b1, 4'h1);
    drive(2'b00, 4'h1, 4'h0);
    tick(); check_main("x_release", 2'b00, 1'b0, 1'b1, 4'h1);
    tick(); check_main("x_idle", 2'b00, 1'b0, 1'b0, 4'h1);

    // Reset restores last=1, then both request
    reset = 1'b1;
    drive(2'b00, 4'h0, 4'h1);
    tick();
    reset = 1'b0;
    check_main("reset2", 2'b00, 1'b0, 1'b0, 4'h0);
    drive(2'b11, 4'h0, 4'h1);
    for (int i = 0; i < 9; i++) begin
      tick();
      check_main($sformatf("rr3_%0d", i), exp_g3[i], exp_s3[i], exp_v3[i], exp_o3[i]);
      check($sformatf("rr2_%0d_grant", i), 32'(bus2.grant), 32'(exp_g2[i]));
      check($sformatf("rr1_%0d_grant", i), 32'(bus1.grant), 32'(exp_g1[i]));
    end

    // Owner 0 releases while y-side starts requesting
    drive(2'b01, 4'h0, 4'h1);
    tick(); check_main("hand_own", 2'b01, 1'b0, 1'b1, 4'h0);
    drive(2'b10, 4'h0, 4'h1);
    tick(); check_main("hand_gap", 2'b00, 1'b1, 1'b1, 4'h0);
    tick(); check_main("hand_new", 2'b10, 1'b1, 1'b0, 4'h0);

    // Waiting requester drops during the gap
    drive(2'b01, 4'h0, 4'h1);
    tick(); check_main("drop_gap", 2'b00, 1'b0, 1'b1, 4'h1);
    drive(2'b10, 4'h0, 4'h1);
    tick(); check_main("drop_back", 2'b10, 1'b1, 1'b0, 4'h1);
    drive(2'b01, 4'h0, 4'h1);
    tick(); check_main("drop_gap2", 2'b00, 1'b0, 1'b1, 4'h1);
    drive(2'b00, 4'h0, 4'h1);
    tick(); check_main("drop_idle", 2'b00, 1'b0, 1'b0, 4'h1);
    tick(); check_main("drop_idle2", 2'b00, 1'b0, 1'b0, 4'h1);

    // Reset in the middle of a y-side grant
    drive(2'b10, 4'h0, 4'h1);
    tick(); check_main("mid_grant", 2'b10, 1'b1, 1'b0, 4'h1);
    tick(); check_main("mid_beat", 2'b10, 1'b1, 1'b1, 4'h1);
    reset = 1'b1;
    drive(2'b11, 4'h0, 4'h1);
    tick(); check_main("mid_reset", 2'b00, 1'b0, 1'b0, 4'h0);
    reset = 1'b0;
    tick(); check_main("mid_after", 2'b01, 1'b0, 1'b0, 4'h0);

    // Uncontended y-side hold is never preempted (MAX_HOLD=2 and 3)
    drive(2'b00, 4'h0, 4'h1);
    tick(); check("solo_idle", 32'(bus2.grant), 32'h0);
    drive(2'b10, 4'h0, 4'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("solo2_%0d", i), 32'(bus2.grant), 32'h2);
      check($sformatf("solo3_%0d", i), 32'(bus3.grant), 32'h2);
    end
    drive(2'b00, 4'h0, 4'h1);
    tick(); check("solo_release", 32'(bus2.grant), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
